// File: rtl/display_pkg.sv
// Shared constants for the display scan path: digit codes, scan state encoding
// and the anode idle level.
package display_pkg;

  localparam logic [1:0] CODE_ERR   = 2'b00;
  localparam logic [1:0] CODE_ONE   = 2'b01;
  localparam logic [1:0] CODE_TWO   = 2'b10;
  localparam logic [1:0] CODE_THREE = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic ANODE_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_BLANK = BLANK,
    ST_SHOW  = SHOW
  } scan_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Terminal-count phase timer: counts 0..i_last while enabled, flags the last
// cycle and wraps to 0 so the next phase starts without a gap.
module scan_timer #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  assign o_done = i_enable && (r_count == i_last);

  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of the order the simulator evaluates processes in.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_done ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller with blanking dead-time between digits.
// Optional per-digit blinking is enabled by defining DISPLAY_SCAN_BLINK_EN.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
`ifdef DISPLAY_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [2*NUM_DIGITS-1:0] DIGITS,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   BLINK_MASK,
`endif
  output logic [1:0]              BCD_SEL,
  output logic [NUM_DIGITS-1:0]   ANODES,
  output logic [((NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1)-1:0] DIGIT_IDX,
  output logic                    FRAME_DONE
);

  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(max2(SHOW_CYCLES, BLANK_CYCLES));
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{ANODE_OFF}};

  scan_state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [1:0]            r_bcd, w_bcd_nxt;
  logic [NUM_DIGITS-1:0] r_anodes, w_anodes_nxt, w_lit;
  logic                  r_frame_done, w_frame_done_nxt;
  logic [CNT_W-1:0]      w_last;
  logic                  w_done;

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  logic [FR_W-1:0] r_frame_cnt;
  logic            r_blink_phase;
`endif

  assign w_last = (r_state == ST_SHOW) ? SHOW_LAST : BLANK_LAST;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clear  (!EN || (r_state == ST_IDLE)),
    .i_enable (EN && (r_state != ST_IDLE)),
    .i_last   (w_last),
    .o_done   (w_done)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_bcd_nxt        = r_bcd;
    w_anodes_nxt     = r_anodes;
    w_frame_done_nxt = 1'b0;

    w_lit        = ALL_OFF;
    w_lit[r_idx] = ~ANODE_OFF;
`ifdef DISPLAY_SCAN_BLINK_EN
    if (r_blink_phase && BLINK_MASK[r_idx]) w_lit[r_idx] = ANODE_OFF;
`endif

    if (!EN) begin
      w_state_nxt  = ST_IDLE;
      w_idx_nxt    = '0;
      w_anodes_nxt = ALL_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_BLANK;
          w_idx_nxt    = '0;
          w_anodes_nxt = ALL_OFF;
        end
        ST_BLANK: if (w_done) begin
          w_state_nxt  = ST_SHOW;
          w_bcd_nxt    = DIGITS[{r_idx, 1'b0} +: 2];
          w_anodes_nxt = w_lit;
        end
        ST_SHOW: if (w_done) begin
          w_state_nxt  = ST_BLANK;
          w_anodes_nxt = ALL_OFF;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt        = '0;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_idx_nxt    = '0;
          w_anodes_nxt = ALL_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_bcd        <= CODE_ERR;
      r_anodes     <= ALL_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_bcd        <= w_bcd_nxt;
      r_anodes     <= w_anodes_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  // Phase flips on the same edge as the wrap, so it applies from digit 0 on.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_done_nxt) begin
      if (r_frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end
`endif

  assign BCD_SEL    = r_bcd;
  assign ANODES     = r_anodes;
  assign DIGIT_IDX  = r_idx;
  assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with SHOW=4, BLANK=2, 4 digits.
module tb_display_scan_controller;
  import display_pkg::*;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [7:0] DIGITS;
  logic [3:0] BLINK_MASK;
  logic [1:0] BCD_SEL;
  logic [3:0] ANODES;
  logic [1:0] DIGIT_IDX;
  logic       FRAME_DONE;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] D_BASE = 8'b11_10_01_00;
  localparam logic [7:0] D_NEW  = 8'b11_10_11_00;

  display_scan_controller #(
    .NUM_DIGITS   (4),
    .SHOW_CYCLES  (4),
    .BLANK_CYCLES (2)
`ifdef DISPLAY_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .DIGITS     (DIGITS),
`ifdef DISPLAY_SCAN_BLINK_EN
    .BLINK_MASK (BLINK_MASK),
`endif
    .BCD_SEL    (BCD_SEL),
    .ANODES     (ANODES),
    .DIGIT_IDX  (DIGIT_IDX),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_blank(input int d, input logic exp_fd);
    check($sformatf("blank anodes d%0d", d), {4'h0, ANODES}, 8'h0F);
    check($sformatf("blank idx d%0d", d), {6'h0, DIGIT_IDX}, 8'(d));
    check($sformatf("blank frame_done d%0d", d), {7'h0, FRAME_DONE}, {7'h0, exp_fd});
  endtask

  task automatic check_show(input int d, input logic [1:0] exp_bcd, input logic lit);
    logic [3:0] exp_an;
    exp_an = lit ? ~(4'b0001 << d) : 4'hF;
    check($sformatf("show anodes d%0d", d), {4'h0, ANODES}, {4'h0, exp_an});
    check($sformatf("show bcd d%0d", d), {6'h0, BCD_SEL}, {6'h0, exp_bcd});
    check($sformatf("show frame_done d%0d", d), {7'h0, FRAME_DONE}, 8'h00);
  endtask

  // One full slot: 2 blank cycles then 4 lit cycles; DIGITS takes mid_digits
  // halfway through the lit interval.
  task automatic run_slot(input int d, input logic [1:0] exp_bcd, input logic exp_fd,
                          input logic lit, input logic [7:0] mid_digits);
    tick(); check_blank(d, exp_fd);
    tick(); check_blank(d, 1'b0);
    tick(); check_show(d, exp_bcd, lit);
    tick(); check_show(d, exp_bcd, lit);
    DIGITS = mid_digits;
    tick(); check_show(d, exp_bcd, lit);
    tick(); check_show(d, exp_bcd, lit);
  endtask

  initial begin
    RST        = 1'b1;
    EN         = 1'b0;
    DIGITS     = D_BASE;
    BLINK_MASK = 4'b0000;
    tick();
    tick();
    check("reset anodes", {4'h0, ANODES}, 8'h0F);
    check("reset bcd", {6'h0, BCD_SEL}, 8'h00);
    check("reset idx", {6'h0, DIGIT_IDX}, 8'h00);
    check("reset frame_done", {7'h0, FRAME_DONE}, 8'h00);
    check("reset state", {6'h0, dut.r_state}, {6'h0, IDLE});

    RST = 1'b0;
    EN  = 1'b1;
    // Frame 0: first blank follows IDLE, so no frame pulse yet.
    run_slot(0, 2'b00, 1'b0, 1'b1, D_BASE);
    run_slot(1, 2'b01, 1'b0, 1'b1, D_BASE);
    run_slot(2, 2'b10, 1'b0, 1'b1, D_BASE);
    run_slot(3, 2'b11, 1'b0, 1'b1, D_BASE);
    // Frame 1: digit 1 changes to 11 mid-slot but keeps showing 01.
    run_slot(0, 2'b00, 1'b1, 1'b1, D_BASE);
    run_slot(1, 2'b01, 1'b0, 1'b1, D_NEW);
    run_slot(2, 2'b10, 1'b0, 1'b1, D_NEW);
    run_slot(3, 2'b11, 1'b0, 1'b1, D_NEW);
    // Frame 2: new code appears; EN drops during digit 2 SHOW.
    run_slot(0, 2'b00, 1'b1, 1'b1, D_NEW);
    run_slot(1, 2'b11, 1'b0, 1'b1, D_NEW);
    tick(); check_blank(2, 1'b0);
    tick(); check_blank(2, 1'b0);
    tick(); check_show(2, 2'b10, 1'b1);
    tick(); check_show(2, 2'b10, 1'b1);
    EN = 1'b0;
    tick();
    check("en drop anodes", {4'h0, ANODES}, 8'h0F);
    check("en drop idx", {6'h0, DIGIT_IDX}, 8'h00);
    check("en drop bcd hold", {6'h0, BCD_SEL}, 8'h02);
    check("en drop frame_done", {7'h0, FRAME_DONE}, 8'h00);
    tick();
    check("en low anodes", {4'h0, ANODES}, 8'h0F);
    check("en low state", {6'h0, dut.r_state}, {6'h0, IDLE});

    EN = 1'b1;
    run_slot(0, 2'b00, 1'b0, 1'b1, D_NEW);
    run_slot(1, 2'b11, 1'b0, 1'b1, D_NEW);
    run_slot(2, 2'b10, 1'b0, 1'b1, D_NEW);
    // Reset for one cycle during digit 3 SHOW.
    tick(); check_blank(3, 1'b0);
    tick(); check_blank(3, 1'b0);
    tick(); check_show(3, 2'b11, 1'b1);
    tick(); check_show(3, 2'b11, 1'b1);
    RST = 1'b1;
    tick();
    check("rst mid anodes", {4'h0, ANODES}, 8'h0F);
    check("rst mid bcd", {6'h0, BCD_SEL}, 8'h00);
    check("rst mid frame_done", {7'h0, FRAME_DONE}, 8'h00);
    check("rst mid idx", {6'h0, DIGIT_IDX}, 8'h00);
    check("rst mid state", {6'h0, dut.r_state}, {6'h0, IDLE});
    RST = 1'b0;
    run_slot(0, 2'b00, 1'b0, 1'b1, D_NEW);
    run_slot(1, 2'b11, 1'b0, 1'b1, D_NEW);
    run_slot(2, 2'b10, 1'b0, 1'b1, D_NEW);
    run_slot(3, 2'b11, 1'b0, 1'b1, D_NEW);
    run_slot(0, 2'b00, 1'b1, 1'b1, D_NEW);

`ifdef DISPLAY_SCAN_BLINK_EN
    // Digit 1 blinks: dark in frames 2-3, lit in 0-1 and 4-5.
    DIGITS     = D_BASE;
    BLINK_MASK = 4'b0010;
    EN         = 1'b0;
    tick();
    check("blink restart anodes", {4'h0, ANODES}, 8'h0F);
    EN = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int d = 0; d < 4; d++) begin
        run_slot(d, 2'(d), (f > 0) && (d == 0), !((d == 1) && (f == 2 || f == 3)), D_BASE);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
